// File: rtl/spike_aer_encoder.sv
`default_nettype none
// ============================================================================
// spike_aer_encoder: captures neuron spike vectors per timestep and emits them
// as AER events over valid/ready. Optional ev_count via SPIKE_AER_EVCNT_EN.
// Revision: 1.0
// ============================================================================
module spike_aer_encoder #(
    parameter int NUM_NEURONS = 16,
    parameter int ADDR_W      = 4,
    parameter int TS_W        = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   step,
    input  logic [NUM_NEURONS-1:0] fired_vec,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [ADDR_W-1:0]      ev_addr,
    output logic [TS_W-1:0]        ev_ts,
    output logic                   ev_last,
    output logic                   busy,
    output logic                   step_done,
    output logic                   overrun,
`ifdef SPIKE_AER_EVCNT_EN
    output logic [15:0]            ev_count,
`endif
    output logic                   overrun_sticky
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [NUM_NEURONS-1:0]   r_pending, w_pending_nxt;
    logic [TS_W-1:0]          r_ts_cnt;
    logic [TS_W-1:0]          r_cap_ts, w_cap_ts_nxt;
    logic                     r_empty, w_empty_nxt;
    logic                     r_step_done;
    logic                     r_overrun;
    logic                     r_sticky;
    logic [ADDR_W-1:0]        w_low_idx;
    logic [NUM_NEURONS-1:0]   w_pending_clr;
    logic                     w_single;
    logic                     w_fire;
    logic                     w_drop;

    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_idx = ADDR_W'(i);
            end
        end
    end

    // x & (x-1) strips the lowest set bit; a zero result means one bit was set
    assign w_pending_clr = r_pending & (r_pending - NUM_NEURONS'(1));
    assign w_single      = (r_pending != '0) && (w_pending_clr == '0);
    assign w_fire        = (r_state == S_EMIT) && ev_ready;
    assign w_drop        = step && (r_state == S_EMIT);

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_cap_ts_nxt  = r_cap_ts;
        w_empty_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (step) begin
                    w_pending_nxt = fired_vec;
                    w_cap_ts_nxt  = r_ts_cnt;
                    if (fired_vec != '0) begin
                        w_state_nxt = S_EMIT;
                    end else begin
                        w_empty_nxt = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (w_fire) begin
                    w_pending_nxt = w_pending_clr;
                    if (w_single) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_ts_cnt    <= '0;
            r_cap_ts    <= '0;
            r_empty     <= 1'b0;
            r_step_done <= 1'b0;
            r_overrun   <= 1'b0;
            r_sticky    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_cap_ts    <= w_cap_ts_nxt;
            r_empty     <= w_empty_nxt;
            r_step_done <= r_empty || (w_fire && w_single);
            r_overrun   <= w_drop;
            if (w_drop) begin
                r_sticky <= 1'b1;
            end
            if (step) begin
                r_ts_cnt <= r_ts_cnt + TS_W'(1);
            end
        end
    end

`ifdef SPIKE_AER_EVCNT_EN
    logic [15:0] r_ev_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ev_count <= '0;
        end else if (w_fire && (r_ev_count != 16'hFFFF)) begin
            r_ev_count <= r_ev_count + 16'd1;
        end
    end

    assign ev_count = r_ev_count;
`endif

    // ev_* are decoded purely from registered state, so they hold while stalled
    assign ev_valid       = (r_state == S_EMIT);
    assign busy           = (r_state == S_EMIT);
    assign ev_addr        = w_low_idx;
    assign ev_ts          = r_cap_ts;
    assign ev_last        = (r_state == S_EMIT) && w_single;
    assign step_done      = r_step_done;
    assign overrun        = r_overrun;
    assign overrun_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_spike_aer_encoder.sv
`default_nettype none
// ============================================================================
// tb_spike_aer_encoder: directed and randomized checks against a queue model.
// Revision: 1.0
// ============================================================================
module tb_spike_aer_encoder;

    logic        clk;
    logic        reset;
    logic        step;
    logic [15:0] fired_vec;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  ev_addr;
    logic [7:0]  ev_ts;
    logic        ev_last;
    logic        busy;
    logic        step_done;
    logic        overrun;
    logic        overrun_sticky;
`ifdef SPIKE_AER_EVCNT_EN
    logic [15:0] ev_count;
`endif

    int errors;
    int checks;
    int ts_model;
    int sticky_model;
    int evcnt_model;

    spike_aer_encoder #(.NUM_NEURONS(16), .ADDR_W(4), .TS_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .step           (step),
        .fired_vec      (fired_vec),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_addr        (ev_addr),
        .ev_ts          (ev_ts),
        .ev_last        (ev_last),
        .busy           (busy),
        .step_done      (step_done),
        .overrun        (overrun),
`ifdef SPIKE_AER_EVCNT_EN
        .ev_count       (ev_count),
`endif
        .overrun_sticky (overrun_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt();
`ifdef SPIKE_AER_EVCNT_EN
        check("ev_count", 32'(ev_count), 32'(evcnt_model));
`endif
    endtask

    // One timestep: vec captured; events drained with the chosen ready pattern.
    // inject_at: emit-cycle index at which a stray step is driven (-1 = none).
    task automatic capture(input logic [15:0] vec, input int rand_ready,
                           input int inject_at, input int stall_at, input int stall_len);
        int q[$];
        int exp_ts;
        int exp_ovr;
        int ovr_nxt;
        int idx;
        int iter;
        int stall_cnt;
        logic rdy;
        exp_ts = ts_model;
        for (int i = 0; i < 16; i++) if (vec[i]) q.push_back(i);
        @(negedge clk);
        step = 1'b1;
        fired_vec = vec;
        ts_model = (ts_model + 1) % 256;
        @(negedge clk);
        step = 1'b0;
        fired_vec = 16'($urandom);
        if (q.size() == 0) begin
            check("empty_valid", 32'(ev_valid), 32'd0);
            check("empty_done_early", 32'(step_done), 32'd0);
            @(negedge clk);
            check("empty_done", 32'(step_done), 32'd1);
            check("empty_busy", 32'(busy), 32'd0);
            @(negedge clk);
            check("empty_done_end", 32'(step_done), 32'd0);
            return;
        end
        exp_ovr = 0;
        idx = 0;
        iter = 0;
        stall_cnt = 0;
        while (q.size() > 0) begin
            if (iter > 300) begin
                check("drain_timeout", 32'd1, 32'd0);
                ev_ready = 1'b0;
                return;
            end
            check("ev_valid", 32'(ev_valid), 32'd1);
            check("ev_addr", 32'(ev_addr), 32'(q[0]));
            check("ev_ts", 32'(ev_ts), 32'(exp_ts));
            check("ev_last", 32'(ev_last), 32'(q.size() == 1));
            check("busy", 32'(busy), 32'd1);
            check("step_done_mid", 32'(step_done), 32'd0);
            check("overrun", 32'(overrun), 32'(exp_ovr));
            check("sticky", 32'(overrun_sticky), 32'(sticky_model));
            check_cnt();
            if (idx == stall_at && stall_cnt < stall_len) begin
                rdy = 1'b0;
                stall_cnt++;
            end else begin
                rdy = (rand_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            ev_ready = rdy;
            ovr_nxt = 0;
            if (iter == inject_at) begin
                step = 1'b1;
                fired_vec = 16'($urandom);
                ts_model = (ts_model + 1) % 256;
                sticky_model = 1;
                ovr_nxt = 1;
            end
            @(negedge clk);
            step = 1'b0;
            if (rdy) begin
                void'(q.pop_front());
                idx++;
                if (evcnt_model < 65535) evcnt_model++;
            end
            exp_ovr = ovr_nxt;
            iter++;
        end
        ev_ready = 1'b0;
        check("end_valid", 32'(ev_valid), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(step_done), 32'd1);
        check("end_overrun", 32'(overrun), 32'(exp_ovr));
        check("end_sticky", 32'(overrun_sticky), 32'(sticky_model));
        check_cnt();
        @(negedge clk);
        check("done_pulse_end", 32'(step_done), 32'd0);
        check("overrun_end", 32'(overrun), 32'd0);
    endtask

    initial begin
        logic [15:0] rv;
        errors = 0;
        checks = 0;
        ts_model = 0;
        sticky_model = 0;
        evcnt_model = 0;
        reset = 1'b0;
        step = 1'b0;
        fired_vec = '0;
        ev_ready = 1'b0;
        #2;
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_last", 32'(ev_last), 32'd0);
        check("rst_done", 32'(step_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_sticky", 32'(overrun_sticky), 32'd0);
        check("rst_addr", 32'(ev_addr), 32'd0);
        check("rst_ts", 32'(ev_ts), 32'd0);
        check_cnt();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        capture(16'h0000, 0, -1, -1, 0);
        capture(16'h8421, 0, -1, -1, 0);
        capture(16'h8421, 0, -1, 1, 3);
        capture(16'h00FF, 0, 1, -1, 0);
        capture(16'h0000, 0, -1, -1, 0);
        capture(16'h0001, 0, 0, -1, 0);
        capture(16'h0003, 0, 1, -1, 0);
        for (int n = 0; n < 8; n++) begin
            rv = 16'($urandom);
            if ($urandom_range(0, 4) == 0) rv = 16'h0000;
            capture(rv, 1, int'($urandom_range(0, 6)) - 2, int'($urandom_range(0, 3)), 2);
        end

        // asynchronous reset while addr 3 of a full vector is on the link
        @(negedge clk);
        step = 1'b1;
        fired_vec = 16'hFFFF;
        @(negedge clk);
        step = 1'b0;
        ev_ready = 1'b1;
        repeat (3) @(negedge clk);
        ev_ready = 1'b0;
        check("pre_rst_addr", 32'(ev_addr), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(ev_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_last", 32'(ev_last), 32'd0);
        check("arst_done", 32'(step_done), 32'd0);
        check("arst_sticky", 32'(overrun_sticky), 32'd0);
        ts_model = 0;
        sticky_model = 0;
        evcnt_model = 0;
        check_cnt();
        @(negedge clk);
        reset = 1'b1;

        for (int n = 0; n < 256; n++) capture(16'h0000, 0, -1, -1, 0);
        capture(16'h0001, 0, -1, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/spike_aer_encoder.md
Name: spike_aer_encoder

Overview:
- Transmit end of the spike path: collects the 1-bit `fired` outputs of NUM_NEURONS LIF neurons once per timestep.
- Serializes them as address-event (AER) packets over a valid/ready link toward the next layer's synapse/current generator.
- Each event carries the neuron index and the timestep of capture; the block sits between a neuron array and the inter-layer fabric.

Parameters:
- NUM_NEURONS, 16, number of neuron spike inputs (2..256)
- ADDR_W, 4, event address width; must equal ceil(log2(NUM_NEURONS))
- TS_W, 8, timestep counter width

Ports:
- clk  input  1  clock, all flops rising-edge
- reset  input  1  asynchronous, active-low reset
- step  input  1  timestep strobe, one cycle wide; samples fired_vec
- fired_vec  input  NUM_NEURONS  spike bits from the neuron array, bit i = neuron i
- ev_valid  output  1  event present on ev_addr/ev_ts/ev_last
- ev_ready  input  1  downstream accepts event
- ev_addr  output  ADDR_W  index of spiking neuron
- ev_ts  output  TS_W  timestep the event was captured in
- ev_last  output  1  final event of the current timestep
- busy  output  1  capture in progress (state EMIT)
- step_done  output  1  one-cycle pulse: all events of a timestep transferred (or none present)
- overrun  output  1  one-cycle pulse: step arrived while busy
- overrun_sticky  output  1  set on any overrun, cleared only by reset

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, pending vector 0, ts counter 0, state IDLE; applies immediately, including mid-burst; in-flight events are discarded.
- ts counter: increments by 1 at every step strobe, accepted or dropped; wraps 2^TS_W-1 -> 0. First step after reset is tagged ts=0.
- IDLE, step=1:
  - pending <= fired_vec; captured_ts <= ts counter.
  - If fired_vec != 0, go to EMIT next cycle.
  - Otherwise stay IDLE and pulse step_done in the following cycle.
- EMIT:
  - ev_valid=1; ev_addr = index of lowest set bit of pending; ev_ts = captured_ts; ev_last=1 iff exactly one bit of pending is set; busy=1.
  - On ev_valid & ev_ready at an edge: clear that bit. The next event is presented in the following cycle with no bubble (1 event/cycle at full ready).
  - After the transfer with ev_last=1: go to IDLE, ev_valid=0, step_done pulses 1 cycle.
- Latency: step sampled at edge N; first ev_valid visible after edge N (cycle N+1). Empty step: step_done visible after edge N+1.
- Stability: while ev_valid=1 and ev_ready=0, ev_addr/ev_ts/ev_last are held unchanged. ev_valid never drops without a handshake except on reset.
- step while busy: fired_vec ignored, pending unchanged, overrun pulses 1 cycle, overrun_sticky set, ts counter still increments.
- step in the same cycle as the final handshake: still counts as busy, so it is dropped with overrun. Upstream must wait for step_done.
- Outputs are driven from flops or decoded from flop state only; no combinational path from ev_ready to ev_valid.

Optional Feature:
- Macro: SPIKE_AER_EVCNT_EN.
- Defined: adds output ev_count [15:0], the total accepted events since reset. Increments on each ev_valid & ev_ready, saturates at 16'hFFFF, resets to 0.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, step with fired_vec=16'h0000 -> no ev_valid; step_done pulses 1 cycle later; next step tagged ts=1.
- fired_vec=16'h8421, ev_ready=1 -> ev_addr 0,5,10,15 on 4 consecutive cycles; ev_ts=0; ev_last=1 only with addr 15; step_done after the 4th handshake.
- Same capture with ev_ready held 0 for 3 cycles on addr 5 -> addr 5 / ts / last stable for all 3 cycles; addr 10 appears the cycle after ready rises.
- step asserted 2 cycles after a capture of 16'h00FF -> overrun pulse, overrun_sticky=1; the 8 events (addr 0..7) still emitted; next accepted step tagged ts=2.
- reset asserted while addr 3 of 16'hFFFF is pending -> ev_valid, busy, ev_last, step_done at 0 immediately (no clock edge); after release, next step tagged ts=0.
- 256 empty steps then step with 16'h0001 -> event addr 0 with ev_ts=0 (wrap); with SPIKE_AER_EVCNT_EN, ev_count=1.
